nn_dma_resp: RTL and testbench
==============================

Name: nn_dma_resp

Overview:
- DMA responder (target side) for the accelerator's byte-wide DMA master interface.
- Services the master's read requests through a request FIFO and a fixed-latency read pipeline, returning data with a one-cycle ready strobe. Absorbs the master's write-backs.
- Exposes a host port so the testbench/SoC can preload images/weights and read back results.
- Sits between nn top-level DMA pins and the system byte memory.

Parameters:
- DMA_ADDR_WIDTH, 5, byte address width; memory depth = 2^DMA_ADDR_WIDTH bytes.
- DATA_WIDTH, 8, memory/DMA data width.
- RD_LATENCY, 2, read pipeline stages between issue and ready (>=1).
- FIFO_DEPTH, 4, outstanding read requests buffered (power of 2, >=2).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-low.
- i_dma_rd_en  in  1  read request from master.
- i_dma_rd_addr  in  DMA_ADDR_WIDTH  read address.
- o_dma_rd_data  out  DATA_WIDTH  returned read data.
- o_dma_rd_ready  out  1  one-cycle strobe; o_dma_rd_data valid this cycle.
- i_dma_wr_en  in  1  write strobe from master.
- i_dma_wr_addr  in  DMA_ADDR_WIDTH  write address.
- i_dma_wr_data  in  DATA_WIDTH  write data.
- i_stall  in  1  memory arbitration stall; blocks issue of new reads.
- i_host_wr_en  in  1  host write strobe.
- i_host_rd_en  in  1  host read strobe.
- i_host_addr  in  DMA_ADDR_WIDTH  host address (shared by rd/wr).
- i_host_wr_data  in  DATA_WIDTH  host write data.
- o_host_rd_data  out  DATA_WIDTH  host read data, registered.
- o_pending  out  $clog2(FIFO_DEPTH+RD_LATENCY)+1  outstanding reads (FIFO + pipe).
- o_err_ovf  out  1  sticky: read request dropped, FIFO full.
- o_err_col  out  1  sticky: host write dropped, collided with DMA write.

Behaviour:
- Reset (i_rst==0 at rising edge):
  - FIFO emptied, pipe valids cleared.
  - o_dma_rd_ready=0, o_dma_rd_data=0, o_host_rd_data=0, o_pending=0, o_err_ovf=0, o_err_col=0.
  - Memory contents retained.
  - Reset mid-operation discards all in-flight reads; no ready strobe is produced for them.
- Request FIFO:
  - i_dma_rd_en pushes i_dma_rd_addr at the edge.
  - Push when full with no pop that cycle: request dropped, o_err_ovf set (cleared only by reset).
  - Push and pop in the same cycle while full: push accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Issue:
  - Each cycle with FIFO non-empty and i_stall==0, pop the head, read memory at the head address, load stage 1 with {valid, data}.
  - Stages advance every cycle; i_stall does not freeze stages already issued.
  - Throughput: one read per cycle.
- Latency: request sampled at edge ending cycle t, FIFO empty, no stall → o_dma_rd_ready=1 in cycle t+1+RD_LATENCY. Each stall cycle adds one cycle.
- Return:
  - o_dma_rd_ready equals the last-stage valid; one cycle per request, in request order.
  - o_dma_rd_data loads on ready and holds its value otherwise.
- Writes:
  - i_dma_wr_en writes memory at the edge.
  - Write-first: a read issued in the same cycle to the same address returns the new data.
  - Host write executes only when i_dma_wr_en==0. If both are asserted, host write is dropped and o_err_col is set, regardless of address.
- Host read: o_host_rd_data = mem[i_host_addr] one cycle after i_host_rd_en, write-first with either write port. Held otherwise.
- o_pending: pushes accepted minus ready strobes, registered. Never exceeds FIFO_DEPTH+RD_LATENCY.
- Read and write ports are independent; the master may read and write in the same cycle.

Test Plan:
- Host preload mem[i]=i+8'h10 for i=0..31; single DMA read addr 5 at cycle t → ready only in cycle t+3, data 8'h15; o_pending 1 then 0.
- Back-to-back DMA reads addr 0..7, no stall → eight consecutive ready strobes, data 8'h10..8'h17 in order; o_err_ovf stays 0.
- Hold i_stall=1, issue 6 reads → first 4 accepted, o_err_ovf=1, o_pending=4. Release stall → exactly 4 ready strobes returning the first four addresses.
- DMA write addr 3 = 8'hAA and DMA read addr 3 issued the same cycle → returned data 8'hAA.
- Host write addr 7 = 8'h55 with DMA write addr 9 = 8'h66 the same cycle → mem[7] unchanged, mem[9]=8'h66, o_err_col=1. Host read addr 9 → 8'h66 next cycle.
- Reset asserted with 3 reads in flight → no ready strobe afterwards; all outputs 0. Memory preload still readable after reset.

Source files
------------

// File: rtl/nn_dma_resp.sv
// DMA target: queues master read requests, returns memory bytes in order, absorbs writes, exposes a host port.
// Latency: read ready strobe RD_LATENCY+1 cycles after the request edge when idle; each stall cycle adds one.
// Backpressure: none toward the master; requests arriving with the FIFO full are dropped and flagged sticky.
module nn_dma_resp #(
    parameter int DMA_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 8,
    parameter int RD_LATENCY     = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_dma_rd_en,
    input  logic [DMA_ADDR_WIDTH-1:0]                 i_dma_rd_addr,
    output logic [DATA_WIDTH-1:0]                     o_dma_rd_data,
    output logic                                      o_dma_rd_ready,
    input  logic                                      i_dma_wr_en,
    input  logic [DMA_ADDR_WIDTH-1:0]                 i_dma_wr_addr,
    input  logic [DATA_WIDTH-1:0]                     i_dma_wr_data,
    input  logic                                      i_stall,
    input  logic                                      i_host_wr_en,
    input  logic                                      i_host_rd_en,
    input  logic [DMA_ADDR_WIDTH-1:0]                 i_host_addr,
    input  logic [DATA_WIDTH-1:0]                     i_host_wr_data,
    output logic [DATA_WIDTH-1:0]                     o_host_rd_data,
    output logic [$clog2(FIFO_DEPTH+RD_LATENCY):0]    o_pending,
    output logic                                      o_err_ovf,
    output logic                                      o_err_col
);
    localparam int MEM_DEPTH = 1 << DMA_ADDR_WIDTH;
    localparam int FPW       = $clog2(FIFO_DEPTH);
    localparam int CW        = FPW + 1;
    localparam int PW        = $clog2(FIFO_DEPTH + RD_LATENCY) + 1;

    logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
    logic [DMA_ADDR_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [FPW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]             fifo_cnt;

    logic                      fifo_empty, fifo_full, pop, push, host_wr;
    logic [DMA_ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]     issue_dat, host_rd_dat;

    logic [RD_LATENCY-1:0]     pipe_vld, stg_in_vld;
    logic [DATA_WIDTH-1:0]     pipe_dat   [RD_LATENCY];
    logic [DATA_WIDTH-1:0]     stg_in_dat [RD_LATENCY];

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign pop        = !fifo_empty && !i_stall;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = i_dma_rd_en && (!fifo_full || pop);
    assign host_wr    = i_host_wr_en && !i_dma_wr_en;
    assign head_addr  = fifo_q[rd_ptr];

    // Write-first bypass for both the issuing read and the host read.
    always_comb begin
        issue_dat = mem[head_addr];
        if (i_dma_wr_en && i_dma_wr_addr == head_addr)
            issue_dat = i_dma_wr_data;
        else if (host_wr && i_host_addr == head_addr)
            issue_dat = i_host_wr_data;

        host_rd_dat = mem[i_host_addr];
        if (i_dma_wr_en && i_dma_wr_addr == i_host_addr)
            host_rd_dat = i_dma_wr_data;
        else if (host_wr)
            host_rd_dat = i_host_wr_data;
    end

    always_comb begin
        stg_in_vld[0] = pop;
        stg_in_dat[0] = issue_dat;
        for (int i = 1; i < RD_LATENCY; i++) begin
            stg_in_vld[i] = pipe_vld[i-1];
            stg_in_dat[i] = pipe_dat[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_dma_wr_en)
            mem[i_dma_wr_addr] <= i_dma_wr_data;
        else if (i_host_wr_en)
            mem[i_host_addr] <= i_host_wr_data;
        if (push)
            fifo_q[wr_ptr] <= i_dma_rd_addr;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            pipe_vld       <= '0;
            for (int i = 0; i < RD_LATENCY; i++)
                pipe_dat[i] <= '0;
            o_host_rd_data <= '0;
            o_pending      <= '0;
            o_err_ovf      <= 1'b0;
            o_err_col      <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FPW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FPW'(1);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);

            // The last stage doubles as the output data register, so it holds between strobes.
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= stg_in_vld[i];
                if (i < RD_LATENCY - 1 || stg_in_vld[i])
                    pipe_dat[i] <= stg_in_dat[i];
            end

            if (i_host_rd_en)
                o_host_rd_data <= host_rd_dat;
            o_pending <= o_pending + PW'(push) - PW'(pipe_vld[RD_LATENCY-1]);
            if (i_dma_rd_en && !push)
                o_err_ovf <= 1'b1;
            if (i_host_wr_en && i_dma_wr_en)
                o_err_col <= 1'b1;
        end
    end

    assign o_dma_rd_ready = pipe_vld[RD_LATENCY-1];
    assign o_dma_rd_data  = pipe_dat[RD_LATENCY-1];
endmodule

// File: tb/tb_nn_dma_resp.sv
// Directed bench for nn_dma_resp: preload, read latency/order, overflow, write-first, collision, reset.
module tb_nn_dma_resp;
    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_dma_rd_en;
    logic [4:0] i_dma_rd_addr;
    logic [7:0] o_dma_rd_data;
    logic       o_dma_rd_ready;
    logic       i_dma_wr_en;
    logic [4:0] i_dma_wr_addr;
    logic [7:0] i_dma_wr_data;
    logic       i_stall;
    logic       i_host_wr_en;
    logic       i_host_rd_en;
    logic [4:0] i_host_addr;
    logic [7:0] i_host_wr_data;
    logic [7:0] o_host_rd_data;
    logic [3:0] o_pending;
    logic       o_err_ovf;
    logic       o_err_col;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic [7:0] rdq [$];
    int         rcyc [$];

    nn_dma_resp dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_dma_rd_en    (i_dma_rd_en),
        .i_dma_rd_addr  (i_dma_rd_addr),
        .o_dma_rd_data  (o_dma_rd_data),
        .o_dma_rd_ready (o_dma_rd_ready),
        .i_dma_wr_en    (i_dma_wr_en),
        .i_dma_wr_addr  (i_dma_wr_addr),
        .i_dma_wr_data  (i_dma_wr_data),
        .i_stall        (i_stall),
        .i_host_wr_en   (i_host_wr_en),
        .i_host_rd_en   (i_host_rd_en),
        .i_host_addr    (i_host_addr),
        .i_host_wr_data (i_host_wr_data),
        .o_host_rd_data (o_host_rd_data),
        .o_pending      (o_pending),
        .o_err_ovf      (o_err_ovf),
        .o_err_col      (o_err_col)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_dma_rd_ready) begin
            rdq.push_back(o_dma_rd_data);
            rcyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},  32'(o_dma_rd_ready), 32'h0);
        chk({tag, "_rdat"}, 32'(o_dma_rd_data),  32'h0);
        chk({tag, "_hdat"}, 32'(o_host_rd_data), 32'h0);
        chk({tag, "_pend"}, 32'(o_pending),      32'h0);
        chk({tag, "_ovf"},  32'(o_err_ovf),      32'h0);
        chk({tag, "_col"},  32'(o_err_col),      32'h0);
    endtask

    function automatic logic [31:0] rdq_at(input int i);
        return (i < rdq.size()) ? 32'(rdq[i]) : 32'hDEAD;
    endfunction

    initial begin
        i_rst = 1'b0; i_dma_rd_en = 0; i_dma_rd_addr = 0; i_dma_wr_en = 0;
        i_dma_wr_addr = 0; i_dma_wr_data = 0; i_stall = 0; i_host_wr_en = 0;
        i_host_rd_en = 0; i_host_addr = 0; i_host_wr_data = 0;
        step(3);
        chk_all_zero("rst");
        i_rst = 1'b1;

        for (int i = 0; i < 32; i++) begin
            i_host_wr_en = 1; i_host_addr = 5'(i); i_host_wr_data = 8'(i + 16);
            step();
        end
        i_host_wr_en = 0;

        // Single read: ready exactly two cycles after the request edge plus one
        i_dma_rd_en = 1; i_dma_rd_addr = 5;
        step();
        i_dma_rd_en = 0;
        chk("t1_pend1", 32'(o_pending), 1);
        chk("t1_rdy_a", 32'(o_dma_rd_ready), 0);
        step();
        chk("t1_rdy_b", 32'(o_dma_rd_ready), 0);
        step();
        chk("t1_rdy_c", 32'(o_dma_rd_ready), 1);
        chk("t1_data", 32'(o_dma_rd_data), 32'h15);
        chk("t1_pend_c", 32'(o_pending), 1);
        step();
        chk("t1_rdy_d", 32'(o_dma_rd_ready), 0);
        chk("t1_pend0", 32'(o_pending), 0);
        chk("t1_hold", 32'(o_dma_rd_data), 32'h15);

        // Back-to-back reads
        rdq.delete(); rcyc.delete();
        for (int i = 0; i < 8; i++) begin
            i_dma_rd_en = 1; i_dma_rd_addr = 5'(i);
            step();
        end
        i_dma_rd_en = 0;
        step(6);
        chk("t2_cnt", 32'(rdq.size()), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_d%0d", i), rdq_at(i), 32'(8'h10 + i));
        if (rcyc.size() == 8)
            chk("t2_span", 32'(rcyc[7] - rcyc[0]), 7);
        else
            chk("t2_span", 32'(rcyc.size()), 8);
        chk("t2_ovf", 32'(o_err_ovf), 0);

        // Overflow under stall
        rdq.delete();
        i_stall = 1;
        for (int i = 0; i < 6; i++) begin
            i_dma_rd_en = 1; i_dma_rd_addr = 5'(10 + i);
            step();
        end
        i_dma_rd_en = 0;
        chk("t3_ovf", 32'(o_err_ovf), 1);
        chk("t3_pend", 32'(o_pending), 4);
        chk("t3_norsp", 32'(rdq.size()), 0);
        i_stall = 0;
        step(8);
        chk("t3_cnt", 32'(rdq.size()), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_d%0d", i), rdq_at(i), 32'(8'h1A + i));
        chk("t3_pend0", 32'(o_pending), 0);

        // Write and read request to the same address in one cycle
        rdq.delete();
        i_dma_rd_en = 1; i_dma_rd_addr = 3;
        i_dma_wr_en = 1; i_dma_wr_addr = 3; i_dma_wr_data = 8'hAA;
        step();
        i_dma_rd_en = 0; i_dma_wr_en = 0;
        step(5);
        chk("t4_cnt", 32'(rdq.size()), 1);
        chk("t4_data", rdq_at(0), 32'hAA);

        // Write landing on the very edge the read issues
        rdq.delete();
        i_dma_rd_en = 1; i_dma_rd_addr = 4;
        step();
        i_dma_rd_en = 0;
        i_dma_wr_en = 1; i_dma_wr_addr = 4; i_dma_wr_data = 8'hBB;
        step();
        i_dma_wr_en = 0;
        step(4);
        chk("t4b_data", rdq_at(0), 32'hBB);
        i_host_rd_en = 1; i_host_addr = 4;
        step();
        i_host_rd_en = 0;
        chk("t4b_host", 32'(o_host_rd_data), 32'hBB);

        // Host/DMA write collision
        chk("t5_col0", 32'(o_err_col), 0);
        i_host_wr_en = 1; i_host_addr = 7; i_host_wr_data = 8'h55;
        i_dma_wr_en = 1; i_dma_wr_addr = 9; i_dma_wr_data = 8'h66;
        step();
        i_host_wr_en = 0; i_dma_wr_en = 0;
        chk("t5_col1", 32'(o_err_col), 1);
        i_host_rd_en = 1; i_host_addr = 9;
        step();
        chk("t5_rd9", 32'(o_host_rd_data), 32'h66);
        i_host_addr = 7;
        step();
        chk("t5_rd7", 32'(o_host_rd_data), 32'h17);
        i_host_wr_en = 1; i_host_addr = 20; i_host_wr_data = 8'h77;
        step();
        i_host_wr_en = 0;
        chk("t5_hwf", 32'(o_host_rd_data), 32'h77);
        i_host_addr = 21; i_dma_wr_en = 1; i_dma_wr_addr = 21; i_dma_wr_data = 8'h99;
        step();
        i_dma_wr_en = 0; i_host_rd_en = 0;
        chk("t5_dwf", 32'(o_host_rd_data), 32'h99);
        i_host_addr = 0;
        step();
        chk("t5_hold", 32'(o_host_rd_data), 32'h99);

        // Reset with three reads in flight
        i_stall = 1;
        i_dma_rd_en = 1; i_dma_rd_addr = 1;
        step();
        i_dma_rd_addr = 2;
        step();
        i_stall = 0; i_dma_rd_addr = 3;
        step();
        i_dma_rd_en = 0;
        chk("t6_pend3", 32'(o_pending), 3);
        rdq.delete();
        i_rst = 1'b0;
        step(2);
        chk_all_zero("t6");
        i_rst = 1'b1;
        step(8);
        chk("t6_norsp", 32'(rdq.size()), 0);
        chk("t6_pend0", 32'(o_pending), 0);
        i_dma_rd_en = 1; i_dma_rd_addr = 5;
        step();
        i_dma_rd_en = 0;
        step(4);
        chk("t6_cnt", 32'(rdq.size()), 1);
        chk("t6_data", rdq_at(0), 32'h15);
        i_host_rd_en = 1; i_host_addr = 9;
        step();
        i_host_rd_en = 0;
        chk("t6_host9", 32'(o_host_rd_data), 32'h66);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
